// File: rtl/note_detect.sv
`default_nettype none
// ============================================================================
// Module   : note_detect
// Purpose  : Tone receiver for the music-box audio path. Measures the full
//            period of an incoming square wave, classifies it into one of
//            the seven scale notes (do..si) and reports a debounced note
//            index together with the last measured period.
// Ports    : clk        - system clock
//            rst        - synchronous reset, active-high
//            tone_in    - asynchronous square-wave input
//            note       - 0 = silence/invalid, 1..7 = do..si
//            note_valid - high while note != 0
//            note_chg   - one-cycle pulse on every change of note
//            period     - last measured full period in clocks (saturates
//                         at TIMEOUT)
// Options  : NOTE_DETECT_GLITCH_EN - when defined, a glitch filter sits
//            between the synchronizer and the edge detector; the filtered
//            level only follows the input after GLITCH_LEN stable cycles.
// Revision : 1.0 - initial release
// ============================================================================

module note_detect #(
    parameter int CLK_HZ     = 25000000,
    parameter int MATCH_CNT  = 3,
    parameter int TIMEOUT    = 131071,
    parameter int GLITCH_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_chg,
    output logic [16:0] period
);

    // ------------------------------------------------------------------
    // Nominal full periods. The tone generator toggles every CLK_HZ/f/2
    // clocks, so the full period is twice that truncated half period.
    // ------------------------------------------------------------------
    localparam int c_P_DO  = 2 * ((CLK_HZ / 262) / 2);
    localparam int c_P_RE  = 2 * ((CLK_HZ / 294) / 2);
    localparam int c_P_MI  = 2 * ((CLK_HZ / 330) / 2);
    localparam int c_P_FA  = 2 * ((CLK_HZ / 349) / 2);
    localparam int c_P_SOL = 2 * ((CLK_HZ / 392) / 2);
    localparam int c_P_LA  = 2 * ((CLK_HZ / 440) / 2);
    localparam int c_P_SI  = 2 * ((CLK_HZ / 494) / 2);

    // Band edges: midpoints between neighbouring nominal periods. The top
    // edge mirrors the do/re midpoint about do; the bottom edge is a fixed
    // fraction of the clock rate (about a 562 Hz upper frequency cutoff).
    localparam logic [16:0] c_EDGE_SI_LO  = 17'((CLK_HZ / 1000) * 89 / 50);
    localparam logic [16:0] c_EDGE_LA_SI  = 17'((c_P_LA  + c_P_SI ) / 2);
    localparam logic [16:0] c_EDGE_SOL_LA = 17'((c_P_SOL + c_P_LA ) / 2);
    localparam logic [16:0] c_EDGE_FA_SOL = 17'((c_P_FA  + c_P_SOL) / 2);
    localparam logic [16:0] c_EDGE_MI_FA  = 17'((c_P_MI  + c_P_FA ) / 2);
    localparam logic [16:0] c_EDGE_RE_MI  = 17'((c_P_RE  + c_P_MI ) / 2);
    localparam logic [16:0] c_EDGE_DO_RE  = 17'((c_P_DO  + c_P_RE ) / 2);
    localparam logic [16:0] c_EDGE_DO_HI  = 17'(2 * c_P_DO - (c_P_DO + c_P_RE) / 2);

    localparam logic [16:0] c_TIMEOUT = 17'(TIMEOUT);
    localparam logic [2:0]  c_MATCH   = 3'(MATCH_CNT);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_lvl;
    logic       r_lvl_d;
    logic       w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], tone_in};
        end
    end

`ifdef NOTE_DETECT_GLITCH_EN
    // ------------------------------------------------------------------
    // Glitch filter: the filtered level follows the synchronized input
    // only after the input has disagreed with it for GLITCH_LEN
    // consecutive cycles. Any return to agreement restarts the count, so
    // shorter pulses never reach the edge detector.
    // ------------------------------------------------------------------
    localparam int              c_GL_W    = $clog2(GLITCH_LEN + 1);
    localparam logic [c_GL_W-1:0] c_GL_LAST = c_GL_W'(GLITCH_LEN - 1);

    logic [c_GL_W-1:0] r_gl_cnt;
    logic              r_gl_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gl_cnt <= '0;
            r_gl_lvl <= 1'b0;
        end else if (r_sync[1] != r_gl_lvl) begin
            if (r_gl_cnt == c_GL_LAST) begin
                r_gl_lvl <= r_sync[1];
                r_gl_cnt <= '0;
            end else begin
                r_gl_cnt <= r_gl_cnt + c_GL_W'(1);
            end
        end else begin
            r_gl_cnt <= '0;
        end
    end

    assign w_lvl = r_gl_lvl;
`else
    assign w_lvl = r_sync[1];

    // GLITCH_LEN has no effect without the filter.
    logic w_unused_glitch_len;
    assign w_unused_glitch_len = (GLITCH_LEN != 0);
`endif

    // ------------------------------------------------------------------
    // Rising-edge detect on the conditioned level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_lvl_d;

    // ------------------------------------------------------------------
    // Period measurement FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t      r_state;
    logic [16:0] r_cnt;
    logic [16:0] r_period;
    logic        r_cls_stb;
    logic        w_timeout;

    // A rising edge on the same cycle as the limit is handled as a normal
    // capture (of TIMEOUT, which classifies as out of band).
    assign w_timeout = (r_state == S_ARMED) && !w_rise && (r_cnt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_cls_stb <= 1'b0;
        end else begin
            r_cls_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The first edge only starts the count; there is no
                    // preceding edge to measure against.
                    if (w_rise) begin
                        r_state <= S_ARMED;
                        r_cnt   <= 17'd1;
                    end
                end
                S_ARMED: begin
                    if (w_rise) begin
                        r_period  <= r_cnt;
                        r_cnt     <= 17'd1;
                        r_cls_stb <= 1'b1;
                    end else if (w_timeout) begin
                        r_period <= c_TIMEOUT;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Classification (half-open bands, registered)
    // ------------------------------------------------------------------
    logic [2:0] w_cand;
    logic [2:0] r_cand;
    logic       r_cand_stb;

    always_comb begin
        w_cand = 3'd0;
        if      (r_period >= c_EDGE_SI_LO  && r_period < c_EDGE_LA_SI ) w_cand = 3'd7;
        else if (r_period >= c_EDGE_LA_SI  && r_period < c_EDGE_SOL_LA) w_cand = 3'd6;
        else if (r_period >= c_EDGE_SOL_LA && r_period < c_EDGE_FA_SOL) w_cand = 3'd5;
        else if (r_period >= c_EDGE_FA_SOL && r_period < c_EDGE_MI_FA ) w_cand = 3'd4;
        else if (r_period >= c_EDGE_MI_FA  && r_period < c_EDGE_RE_MI ) w_cand = 3'd3;
        else if (r_period >= c_EDGE_RE_MI  && r_period < c_EDGE_DO_RE ) w_cand = 3'd2;
        else if (r_period >= c_EDGE_DO_RE  && r_period < c_EDGE_DO_HI ) w_cand = 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand     <= 3'd0;
            r_cand_stb <= 1'b0;
        end else begin
            r_cand     <= w_cand;
            r_cand_stb <= r_cls_stb;
        end
    end

    // ------------------------------------------------------------------
    // Match / debounce logic
    // ------------------------------------------------------------------
    logic [2:0] r_prev_cand;
    logic [2:0] r_match;
    logic [2:0] w_match_nxt;
    logic [2:0] r_note;
    logic       r_note_chg;

    always_comb begin
        w_match_nxt = 3'd1;
        if (r_cand == r_prev_cand) begin
            w_match_nxt = (r_match >= c_MATCH) ? c_MATCH : r_match + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_cand <= 3'd0;
            r_match     <= 3'd0;
            r_note      <= 3'd0;
            r_note_chg  <= 1'b0;
        end else begin
            r_note_chg <= 1'b0;
            if (w_timeout) begin
                // Silence is reported immediately, without debouncing.
                r_match <= 3'd0;
                if (r_note != 3'd0) begin
                    r_note     <= 3'd0;
                    r_note_chg <= 1'b1;
                end
            end else if (r_cand_stb) begin
                r_prev_cand <= r_cand;
                r_match     <= w_match_nxt;
                if (w_match_nxt == c_MATCH && r_cand != r_note) begin
                    r_note     <= r_cand;
                    r_note_chg <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign note       = r_note;
    assign note_valid = (r_note != 3'd0);
    assign note_chg   = r_note_chg;
    assign period     = r_period;

endmodule

`default_nettype wire

// File: tb/tb_note_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_detect
// Purpose  : Self-checking bench for note_detect. The DUT runs with
//            CLK_HZ = 250000 so every tone period is 1/100 of the 25 MHz
//            value. Scaled nominal periods: do 954, re 850, mi 756,
//            fa 716, sol 636, la 568, si 506. Scaled band edges:
//            si [445,537) la [537,602) sol [602,676) fa [676,736)
//            mi [736,803) re [803,902) do [902,1006). TIMEOUT = 1500.
//            Each tone period is a low phase followed by a fixed 100-cycle
//            high phase, so rise-to-rise spacing equals the requested
//            period independent of the previous one.
// Revision : 1.0 - initial release
// ============================================================================

module tb_note_detect;

    localparam int H0  = 100;
    localparam int TMO = 1500;
`ifdef NOTE_DETECT_GLITCH_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        tone_in;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_chg;
    logic [16:0] period;

    note_detect #(
        .CLK_HZ     (250000),
        .MATCH_CNT  (3),
        .TIMEOUT    (TMO),
        .GLITCH_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .note       (note),
        .note_valid (note_valid),
        .note_chg   (note_chg),
        .period     (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int chg_cnt = 0;

    always @(negedge clk) begin
        if (note_chg === 1'b1) chg_cnt++;
    end

    typedef struct {
        int p;
        int n;
        int exp_period;
        int exp_note;
        int exp_chg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Precondition: a rising edge has just been followed by its high phase.
    task automatic tone_periods(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            tone_in = 1'b0;
            wait_cyc(p - H0);
            tone_in = 1'b1;
            wait_cyc(H0);
        end
    endtask

    // Sol period with a 2-cycle high glitch in the middle of the low phase.
    task automatic glitch_period();
        tone_in = 1'b0;
        wait_cyc(268);
        tone_in = 1'b1;
        wait_cyc(2);
        tone_in = 1'b0;
        wait_cyc(266);
        tone_in = 1'b1;
        wait_cyc(H0);
    endtask

    task automatic arm();
        tone_in = 1'b0;
        wait_cyc(20);
        tone_in = 1'b1;
        wait_cyc(H0);
    endtask

    initial begin
        int c0;

        //            p     n  period note chg
        vecs.push_back('{ 636, 2,  636, 0, 0});  // sol x2: not yet debounced
        vecs.push_back('{ 636, 1,  636, 5, 1});  // 3rd sol: note = 5
        vecs.push_back('{ 636, 2,  636, 5, 0});  // steady sol, no re-pulse
        vecs.push_back('{ 568, 3,  568, 6, 1});  // la
        vecs.push_back('{ 954, 2,  954, 6, 0});  // do x2: still la
        vecs.push_back('{ 954, 1,  954, 1, 1});  // 3rd do
        vecs.push_back('{ 756, 3,  756, 3, 1});  // mi
        vecs.push_back('{ 300, 2,  300, 3, 0});  // too fast x2
        vecs.push_back('{ 300, 1,  300, 0, 1});  // 3rd too fast: silence
        vecs.push_back('{ 850, 1,  850, 0, 0});  // alternating re/mi
        vecs.push_back('{ 756, 1,  756, 0, 0});
        vecs.push_back('{ 850, 1,  850, 0, 0});
        vecs.push_back('{ 756, 1,  756, 0, 0});
        vecs.push_back('{ 601, 3,  601, 6, 1});  // sol/la edge - 1
        vecs.push_back('{ 602, 3,  602, 5, 1});  // sol/la edge
        vecs.push_back('{ 536, 3,  536, 7, 1});  // la/si edge - 1
        vecs.push_back('{ 537, 3,  537, 6, 1});  // la/si edge
        vecs.push_back('{1005, 3, 1005, 1, 1});  // top edge - 1
        vecs.push_back('{1006, 3, 1006, 0, 1});  // top edge
        vecs.push_back('{ 445, 3,  445, 7, 1});  // bottom edge
        vecs.push_back('{ 444, 3,  444, 0, 1});  // bottom edge - 1
        vecs.push_back('{ 902, 3,  902, 1, 1});  // do/re edge
        vecs.push_back('{ 901, 3,  901, 2, 1});  // do/re edge - 1
        vecs.push_back('{ 803, 3,  803, 2, 0});  // re/mi edge, same note
        vecs.push_back('{ 802, 3,  802, 3, 1});  // re/mi edge - 1
        vecs.push_back('{ 736, 3,  736, 3, 0});  // mi/fa edge
        vecs.push_back('{ 735, 3,  735, 4, 1});  // mi/fa edge - 1
        vecs.push_back('{ 676, 3,  676, 4, 0});  // fa/sol edge
        vecs.push_back('{ 675, 3,  675, 5, 1});  // fa/sol edge - 1
        vecs.push_back('{ 506, 3,  506, 7, 1});  // si

        // ---------------- reset state ----------------
        rst     = 1'b1;
        tone_in = 1'b0;
        wait_cyc(4);
        check("rst note", note, 0);
        check("rst note_valid", note_valid, 0);
        check("rst note_chg", note_chg, 0);
        check("rst period", period, 0);
        rst = 1'b0;
        wait_cyc(2);

        // ---------------- first edge only arms ----------------
        arm();
        check("arm period", period, 0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            c0 = chg_cnt;
            tone_periods(vecs[i].p, vecs[i].n);
            check($sformatf("v%0d period", i), period, vecs[i].exp_period);
            check($sformatf("v%0d note", i), note, vecs[i].exp_note);
            check($sformatf("v%0d note_valid", i), note_valid, (vecs[i].exp_note != 0) ? 1 : 0);
            check($sformatf("v%0d note_chg count", i), chg_cnt - c0, vecs[i].exp_chg);
        end

        // ---------------- timeout after si ----------------
        // Counter restarts LAT cycles after the last rise; note drops
        // exactly TMO cycles after that.
        tone_in = 1'b0;
        wait_cyc(LAT + TMO - 1 - H0);
        check("tmo note before", note, 7);
        check("tmo chg before", note_chg, 0);
        wait_cyc(1);
        check("tmo note", note, 0);
        check("tmo note_chg", note_chg, 1);
        check("tmo period", period, TMO);
        check("tmo note_valid", note_valid, 0);
        wait_cyc(1);
        check("tmo note_chg single", note_chg, 0);

        // Back in IDLE: next edge only arms.
        arm();
        check("post-tmo arm period", period, TMO);
        c0 = chg_cnt;
        tone_periods(716, 3);
        check("fa period", period, 716);
        check("fa note", note, 4);
        check("fa note_chg count", chg_cnt - c0, 1);

        // ---------------- reset mid-period ----------------
        tone_in = 1'b0;
        wait_cyc(200);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst note", note, 0);
        check("midrst note_valid", note_valid, 0);
        check("midrst note_chg", note_chg, 0);
        check("midrst period", period, 0);
        rst = 1'b0;
        arm();
        check("midrst arm period", period, 0);
        tone_periods(716, 1);
        check("midrst first period", period, 716);
        check("midrst first note", note, 0);

        c0 = chg_cnt;
        tone_periods(636, 3);
        check("pre-glitch note", note, 5);
        check("pre-glitch note_chg count", chg_cnt - c0, 1);

        // ---------------- glitches in sol low phase ----------------
        c0 = chg_cnt;
        glitch_period();
        glitch_period();
        glitch_period();
`ifdef NOTE_DETECT_GLITCH_EN
        check("glitch period", period, 636);
        check("glitch note", note, 5);
        check("glitch note_chg count", chg_cnt - c0, 0);
`else
        // Each glitch splits the period into 368 + 268, both out of band.
        check("glitch period", period, 268);
        check("glitch note", note, 0);
        check("glitch note_chg count", chg_cnt - c0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
